// File: rtl/hidden_layer_sequencer.sv
// Sequences one inference pass: stream a vector into a hidden layer, capture its result.
// Optional WAIT-state watchdog enabled by defining LAYER_TIMEOUT_EN.
module hidden_layer_sequencer #(
    parameter int NUM_INPUTS     = 4,
    parameter int NUM_OUTPUTS    = 4,
    parameter int WIDTH          = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [NUM_INPUTS*WIDTH-1:0]  IN_VECTOR,
    input  logic                         IN_VALID,
    output logic                         IN_READY,
    input  logic                         L_READY,
    output logic [WIDTH-1:0]             L_VALUE_IN,
    output logic                         L_VALID_IN,
    input  logic [NUM_OUTPUTS*WIDTH-1:0] L_VALUES_OUT,
    input  logic [NUM_OUTPUTS-1:0]       L_VALIDS_OUT,
    input  logic                         L_OVERFLOW,
    output logic [NUM_OUTPUTS*WIDTH-1:0] OUT_VECTOR,
    output logic                         OUT_VALID,
    input  logic                         OUT_READY,
    output logic                         OUT_OVERFLOW,
    output logic                         OUT_TIMEOUT,
    output logic                         BUSY
);

    localparam int IW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_INPUTS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_WAIT,
        S_OUT
    } state_t;

    state_t state_q, state_d;

    logic [IW-1:0]                  idx_q;
    logic [WIDTH-1:0]               vec_q [NUM_INPUTS];
    logic                           sticky_q;
    logic [NUM_OUTPUTS*WIDTH-1:0]   out_vec_q;
    logic                           out_ovf_q;
    logic                           accept;
    logic                           all_valid;
    logic                           capture;
    logic                           expire;
    logic                           enter_out;

    assign all_valid = &L_VALIDS_OUT;
    assign accept    = (state_q == S_IDLE) && IN_VALID;
    assign capture   = (state_q == S_WAIT) && all_valid;
    assign enter_out = (state_q == S_WAIT) && (state_d == S_OUT);

`ifdef LAYER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic          out_tmo_q;

    // Counter is zero on WAIT entry because it is held clear everywhere else.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q     <= '0;
            out_tmo_q <= 1'b0;
        end else begin
            if (state_q == S_WAIT) cnt_q <= cnt_q + 1'b1;
            else                   cnt_q <= '0;
            if (accept)      out_tmo_q <= 1'b0;
            else if (expire) out_tmo_q <= 1'b1;
        end
    end

    assign expire      = (state_q == S_WAIT) && !all_valid && (cnt_q == CNT_LAST);
    assign OUT_TIMEOUT = out_tmo_q;
`else
    assign expire      = 1'b0;
    // Watchdog not built; the parameter only matters when it is.
    assign OUT_TIMEOUT = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

    always_comb begin
        state_d    = state_q;
        IN_READY   = 1'b0;
        BUSY       = 1'b1;
        L_VALID_IN = 1'b0;
        L_VALUE_IN = '0;
        OUT_VALID  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                IN_READY = 1'b1;
                BUSY     = 1'b0;
                if (IN_VALID) state_d = S_FEED;
            end
            S_FEED: begin
                L_VALID_IN = L_READY;
                L_VALUE_IN = vec_q[idx_q];
                if (L_READY && (idx_q == LAST_IDX)) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (all_valid || expire) state_d = S_OUT;
            end
            S_OUT: begin
                OUT_VALID = 1'b1;
                if (OUT_READY) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            sticky_q  <= 1'b0;
            out_vec_q <= '0;
            out_ovf_q <= 1'b0;
            for (int i = 0; i < NUM_INPUTS; i++) vec_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                for (int i = 0; i < NUM_INPUTS; i++)
                    vec_q[i] <= IN_VECTOR[i*WIDTH +: WIDTH];
                idx_q     <= '0;
                sticky_q  <= 1'b0;
                out_ovf_q <= 1'b0;
            end
            if (L_VALID_IN)
                idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
            if ((state_q == S_FEED) || (state_q == S_WAIT))
                sticky_q <= sticky_q | L_OVERFLOW;
            // Capture cycle overflow is folded into the presented flag.
            if (enter_out)
                out_ovf_q <= sticky_q | L_OVERFLOW;
            if (capture)     out_vec_q <= L_VALUES_OUT;
            else if (expire) out_vec_q <= '0;
        end
    end

    assign OUT_VECTOR   = out_vec_q;
    assign OUT_OVERFLOW = out_ovf_q;

endmodule
